// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, instruction fields, FSM states.
// Latency: none (constants, types and pure functions only).
// Backpressure: not applicable.
package fd_pkg;

    localparam int INSTR_W = 24;

    // Opcodes with a distinct decode; every other value is a plain register-writing op.
    localparam logic [4:0] IMML       = 5'b00110;
    localparam logic [4:0] IMMH       = 5'b00111;
    localparam logic [4:0] BRANCH     = 5'b01000;
    localparam logic [4:0] BRANCH_REG = 5'b01001;
    localparam logic [4:0] LOAD       = 5'b01010;
    localparam logic [4:0] STORE      = 5'b01011;
    localparam logic [4:0] DBLOAD     = 5'b01100;
    localparam logic [4:0] DBSTORE    = 5'b01101;

    // Field positions inside the 24-bit instruction; sr2 aliases the low nibble of imm8.
    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 4;
    localparam int RD_LSB   = 5;
    localparam int RD_MSB   = 8;
    localparam int SR1_LSB  = 9;
    localparam int SR1_MSB  = 12;
    localparam int SR2_LSB  = 13;
    localparam int SR2_MSB  = 16;
    localparam int IMM_LSB  = 13;
    localparam int IMM_MSB  = 20;
    localparam int COND_LSB = 21;
    localparam int COND_MSB = 23;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fdState_t;

    typedef struct packed {
        logic memRead;
        logic memWrite;
        logic memtoReg;
        logic bustoReg;
        logic busWrite;
        logic aluSrc;
    } fdCtrl_t;

    function automatic logic isMemOp(input logic [4:0] op);
        return (op == LOAD) || (op == STORE) || (op == DBLOAD) || (op == DBSTORE);
    endfunction

    function automatic logic writesRd(input logic [4:0] op);
        return !((op == STORE) || (op == DBSTORE) || (op == BRANCH) || (op == BRANCH_REG));
    endfunction

    function automatic fdCtrl_t decodeCtrl(input logic [4:0] op);
        fdCtrl_t c;
        c          = '0;
        c.memRead  = (op == LOAD);
        c.memtoReg = (op == LOAD);
        c.memWrite = (op == STORE);
        c.bustoReg = (op == DBLOAD);
        c.busWrite = (op == DBSTORE);
        c.aluSrc   = isMemOp(op);
        return c;
    endfunction

endpackage

// File: rtl/fetch_decode_pipe_ccode.sv
// Branch condition evaluator: each cond bit selects one of the N, V, Z flags; true if any selected flag is set.
// Latency: combinational.
// Backpressure: none.
module CCodeEval (
    input  logic [2:0] cond,
    input  logic [2:0] NVZ,
    output logic       cond_true
);

    assign cond_true = |(cond & NVZ);

endmodule

// File: rtl/fetch_decode_pipe.sv
// Fetch/decode front end: owns the PC, requests instructions, decodes, reads the register file into FD/EX.
// Latency: an instruction presented with iInstrValid appears in FD/EX one clock later.
// Backpressure: iStall freezes PC and FD/EX; flush and load-use hazards insert bubbles. Define RF_BYPASS_EN to forward same-cycle writeback.
module fetch_decode_pipe
    import fd_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int PC_STEP  = 3,
    parameter int NUM_REGS = 16
) (
    input  logic                iclk,
    input  logic                irst_n,
    output logic [ADDR_W-1:0]   oInstrAddr,
    output logic                oInstrReq,
    input  logic [INSTR_W-1:0]  iInstr,
    input  logic                iInstrValid,
    input  logic                iStall,
    input  logic                iFlush,
    input  logic [2:0]          iNVZ,
    input  logic                iWriteReg,
    input  logic [3:0]          iWriteRegAddr,
    input  logic [DATA_W-1:0]   iWriteRegData,
    output logic                oValid,
    output logic [4:0]          oOpcode,
    output logic [DATA_W-1:0]   oData1,
    output logic [DATA_W-1:0]   oData2,
    output logic [DATA_W-1:0]   oImm,
    output logic [3:0]          oSr1,
    output logic [3:0]          oSr2,
    output logic                oWriteReg,
    output logic [3:0]          oWriteRegAddr,
    output logic                oMemRead,
    output logic                oMemWrite,
    output logic                oMemtoReg,
    output logic                oBustoReg,
    output logic                oBusWrite,
    output logic                oALUSrc
);

    logic [4:0]        curOp;
    logic [3:0]        curRd;
    logic [3:0]        curSr1;
    logic [3:0]        curSr2;
    logic [7:0]        curImm8;
    logic [2:0]        curCond;
    logic [DATA_W-1:0] curImm;
    logic              curWr;
    fdCtrl_t           curCtrl;
    fdCtrl_t           ctrlQ;

    logic [DATA_W-1:0] regFile [NUM_REGS];
    logic [DATA_W-1:0] rdData1;
    logic [DATA_W-1:0] rdData2;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcNext;
    logic [ADDR_W-1:0] sextImm;
    logic [ADDR_W-1:0] brOffset;
    logic              reqEn;
    logic              condTrue;

    fdState_t          state;
    fdState_t          stateNext;
    logic              fire;
    logic              hazard;
    logic              doLoad;
    logic              doBubble;

    assign curOp   = iInstr[OPC_MSB:OPC_LSB];
    assign curRd   = iInstr[RD_MSB:RD_LSB];
    assign curSr1  = iInstr[SR1_MSB:SR1_LSB];
    assign curSr2  = iInstr[SR2_MSB:SR2_LSB];
    assign curImm8 = iInstr[IMM_MSB:IMM_LSB];
    assign curCond = iInstr[COND_MSB:COND_LSB];
    assign curWr   = writesRd(curOp);
    assign curCtrl = decodeCtrl(curOp);

    CCodeEval uCond (
        .cond      (curCond),
        .NVZ       (iNVZ),
        .cond_true (condTrue)
    );

`ifdef RF_BYPASS_EN
    assign rdData1 = (iWriteReg && (iWriteRegAddr == curSr1)) ? iWriteRegData : regFile[curSr1];
    assign rdData2 = (iWriteReg && (iWriteRegAddr == curSr2)) ? iWriteRegData : regFile[curSr2];
`else
    assign rdData1 = regFile[curSr1];
    assign rdData2 = regFile[curSr2];
`endif

    // An instruction only counts once a request has actually been issued for it.
    assign fire   = reqEn && iInstrValid;
    assign hazard = fire && oValid && ((oOpcode == LOAD) || (oOpcode == DBLOAD)) &&
                    ((oWriteRegAddr == curSr1) || (oWriteRegAddr == curSr2));

    assign sextImm  = {{(ADDR_W-8){curImm8[7]}}, curImm8};
    assign brOffset = (sextImm + ADDR_W'(1)) * ADDR_W'(PC_STEP);

    // Formatted immediate for the decoded opcode.
    always_comb begin
        curImm = '0;
        if (curOp == IMML) begin
            curImm = DATA_W'(curImm8);
        end else if (curOp == IMMH) begin
            curImm = DATA_W'({curImm8, 8'h00});
        end else if (isMemOp(curOp)) begin
            curImm = {{(DATA_W-8){curImm8[7]}}, curImm8};
        end
    end

    // Register file: writeback port, cleared on reset.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (iWriteReg) begin
            regFile[iWriteRegAddr] <= iWriteRegData;
        end
    end

    // FSM state register.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state: HOLD tracks a downstream stall, WAIT tracks a missing instruction.
    always_comb begin
        stateNext = state;
        case (state)
            FETCH, WAIT: begin
                if (iStall)     stateNext = HOLD;
                else if (fire)  stateNext = FETCH;
                else if (reqEn) stateNext = WAIT;
                else            stateNext = FETCH;
            end
            HOLD: begin
                if (iStall)           stateNext = HOLD;
                else if (iInstrValid) stateNext = FETCH;
                else                  stateNext = WAIT;
            end
            default: stateNext = FETCH;
        endcase
    end

    // FSM outputs: flush beats hazard beats stall; with nothing to decode a bubble enters FD/EX.
    always_comb begin
        doLoad   = 1'b0;
        doBubble = 1'b0;
        if (iFlush || hazard) begin
            doBubble = 1'b1;
        end else if (iStall) begin
            doBubble = 1'b0;
        end else if (fire) begin
            doLoad = 1'b1;
        end else begin
            doBubble = 1'b1;
        end
    end

    // Next PC: only a decoded instruction advances it; all arithmetic wraps at ADDR_W.
    always_comb begin
        pcNext = pc;
        if (doLoad) begin
            if ((curOp == BRANCH) && condTrue) begin
                pcNext = pc + brOffset;
            end else if ((curOp == BRANCH_REG) && condTrue) begin
                pcNext = ADDR_W'(rdData1);
            end else begin
                pcNext = pc + ADDR_W'(PC_STEP);
            end
        end
    end

    // PC and request enable; the request rises on the first clock after reset.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            pc    <= '0;
            reqEn <= 1'b0;
        end else begin
            pc    <= pcNext;
            reqEn <= 1'b1;
        end
    end

    assign oInstrAddr = pc;
    assign oInstrReq  = reqEn;

    // FD/EX pipeline register: load, clear to bubble, or hold.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oValid        <= 1'b0;
            oOpcode       <= '0;
            oData1        <= '0;
            oData2        <= '0;
            oImm          <= '0;
            oSr1          <= '0;
            oSr2          <= '0;
            oWriteReg     <= 1'b0;
            oWriteRegAddr <= '0;
            ctrlQ         <= '0;
        end else if (doLoad) begin
            oValid        <= 1'b1;
            oOpcode       <= curOp;
            oData1        <= rdData1;
            oData2        <= rdData2;
            oImm          <= curImm;
            oSr1          <= curSr1;
            oSr2          <= curSr2;
            oWriteReg     <= curWr;
            oWriteRegAddr <= curWr ? curRd : 4'd0;
            ctrlQ         <= curCtrl;
        end else if (doBubble) begin
            oValid        <= 1'b0;
            oOpcode       <= '0;
            oData1        <= '0;
            oData2        <= '0;
            oImm          <= '0;
            oSr1          <= '0;
            oSr2          <= '0;
            oWriteReg     <= 1'b0;
            oWriteRegAddr <= '0;
            ctrlQ         <= '0;
        end
    end

    assign oMemRead  = ctrlQ.memRead;
    assign oMemWrite = ctrlQ.memWrite;
    assign oMemtoReg = ctrlQ.memtoReg;
    assign oBustoReg = ctrlQ.bustoReg;
    assign oBusWrite = ctrlQ.busWrite;
    assign oALUSrc   = ctrlQ.aluSrc;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Bench for fetch_decode_pipe: directed per-cycle vectors queue the expected FD/EX and PC state.
// A negedge monitor pops the expectation due for the current cycle and compares it.
// Build with RF_BYPASS_EN to check the same-cycle writeback forwarding.
module tb_fetch_decode_pipe;

    localparam logic [4:0] OP_ADD     = 5'b00001;
    localparam logic [4:0] OP_IMML    = 5'b00110;
    localparam logic [4:0] OP_IMMH    = 5'b00111;
    localparam logic [4:0] OP_BR      = 5'b01000;
    localparam logic [4:0] OP_BRREG   = 5'b01001;
    localparam logic [4:0] OP_LOAD    = 5'b01010;
    localparam logic [4:0] OP_STORE   = 5'b01011;
    localparam logic [4:0] OP_DBLOAD  = 5'b01100;
    localparam logic [4:0] OP_DBSTORE = 5'b01101;

`ifdef RF_BYPASS_EN
    localparam logic [15:0] R5_SAME_CYCLE = 16'hBEEF;
`else
    localparam logic [15:0] R5_SAME_CYCLE = 16'h0000;
`endif

    logic        iclk;
    logic        irst_n;
    logic [15:0] oInstrAddr;
    logic        oInstrReq;
    logic [23:0] iInstr;
    logic        iInstrValid;
    logic        iStall;
    logic        iFlush;
    logic [2:0]  iNVZ;
    logic        iWriteReg;
    logic [3:0]  iWriteRegAddr;
    logic [15:0] iWriteRegData;
    logic        oValid;
    logic [4:0]  oOpcode;
    logic [15:0] oData1;
    logic [15:0] oData2;
    logic [15:0] oImm;
    logic [3:0]  oSr1;
    logic [3:0]  oSr2;
    logic        oWriteReg;
    logic [3:0]  oWriteRegAddr;
    logic        oMemRead;
    logic        oMemWrite;
    logic        oMemtoReg;
    logic        oBustoReg;
    logic        oBusWrite;
    logic        oALUSrc;

    fetch_decode_pipe #(
        .DATA_W(16), .ADDR_W(16), .PC_STEP(3), .NUM_REGS(16)
    ) dut (
        .iclk(iclk), .irst_n(irst_n),
        .oInstrAddr(oInstrAddr), .oInstrReq(oInstrReq),
        .iInstr(iInstr), .iInstrValid(iInstrValid),
        .iStall(iStall), .iFlush(iFlush), .iNVZ(iNVZ),
        .iWriteReg(iWriteReg), .iWriteRegAddr(iWriteRegAddr), .iWriteRegData(iWriteRegData),
        .oValid(oValid), .oOpcode(oOpcode), .oData1(oData1), .oData2(oData2), .oImm(oImm),
        .oSr1(oSr1), .oSr2(oSr2), .oWriteReg(oWriteReg), .oWriteRegAddr(oWriteRegAddr),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemtoReg(oMemtoReg),
        .oBustoReg(oBustoReg), .oBusWrite(oBusWrite), .oALUSrc(oALUSrc)
    );

    typedef struct {
        int          cyc;
        logic        full;
        logic [15:0] pc;
        logic        req;
        logic        vld;
        logic [4:0]  op;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] imm;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        wr;
        logic [3:0]  wra;
        logic [5:0]  ctrl;
    } exp_t;

    exp_t expQ[$];
    int   cycCnt = 0;
    int   nTests = 0;
    int   nFail  = 0;

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(posedge iclk) begin
        if (irst_n) cycCnt <= cycCnt + 1;
    end

    function automatic logic [23:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] s1, input logic [7:0] imm8,
                                        input logic [2:0] cond);
        return {cond, imm8, s1, rd, op};
    endfunction

    function automatic exp_t mk(input logic [15:0] pc, input logic [4:0] op,
                                input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] imm,
                                input logic [3:0] s1, input logic [3:0] s2,
                                input logic wr, input logic [3:0] wra, input logic [5:0] ctrl);
        exp_t e;
        e.cyc = 0; e.full = 1'b1; e.pc = pc; e.req = 1'b1; e.vld = 1'b1;
        e.op = op; e.d1 = d1; e.d2 = d2; e.imm = imm; e.s1 = s1; e.s2 = s2;
        e.wr = wr; e.wra = wra; e.ctrl = ctrl;
        return e;
    endfunction

    function automatic exp_t mkB(input logic [15:0] pc);
        exp_t e;
        e = mk(pc, 5'd0, 16'd0, 16'd0, 16'd0, 4'd0, 4'd0, 1'b0, 4'd0, 6'd0);
        e.vld  = 1'b0;
        e.full = 1'b0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv, input int c);
        nTests++;
        if (act !== expv) begin
            nFail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, c, act, expv);
        end
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge iclk) begin : monitor
        exp_t m;
        while (expQ.size() > 0 && expQ[0].cyc == cycCnt) begin
            m = expQ.pop_front();
            chk("pc",   oInstrAddr, m.pc, m.cyc);
            chk("req",  16'(oInstrReq), 16'(m.req), m.cyc);
            chk("vld",  16'(oValid), 16'(m.vld), m.cyc);
            chk("ctrl", 16'({oMemRead, oMemWrite, oMemtoReg, oBustoReg, oBusWrite, oALUSrc}),
                16'(m.ctrl), m.cyc);
            chk("wr",   16'(oWriteReg), 16'(m.wr), m.cyc);
            chk("wra",  16'(oWriteRegAddr), 16'(m.wra), m.cyc);
            if (m.full) begin
                chk("op",   16'(oOpcode), 16'(m.op), m.cyc);
                chk("d1",   oData1, m.d1, m.cyc);
                chk("d2",   oData2, m.d2, m.cyc);
                chk("imm",  oImm, m.imm, m.cyc);
                chk("sr1",  16'(oSr1), 16'(m.s1), m.cyc);
                chk("sr2",  16'(oSr2), 16'(m.s2), m.cyc);
            end
        end
    end

    task automatic step(input logic [23:0] instr, input logic ivld, input logic [2:0] nvz,
                        input logic stall, input logic flush,
                        input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input exp_t e);
        exp_t t;
        iInstr        = instr;
        iInstrValid   = ivld;
        iNVZ          = nvz;
        iStall        = stall;
        iFlush        = flush;
        iWriteReg     = we;
        iWriteRegAddr = wa;
        iWriteRegData = wd;
        t     = e;
        t.cyc = cycCnt + 1;
        expQ.push_back(t);
        @(posedge iclk);
        #1;
    endtask

    initial begin : stim
        exp_t r;
        exp_t e16;
        irst_n = 1'b0;
        iInstr = '0; iInstrValid = 1'b0; iStall = 1'b0; iFlush = 1'b0; iNVZ = '0;
        iWriteReg = 1'b0; iWriteRegAddr = '0; iWriteRegData = '0;

        // Reset state: everything zero, no request yet.
        r = mkB(16'h0000);
        r.req = 1'b0; r.full = 1'b1;
        r.cyc = 0;
        expQ.push_back(r);
        #22;
        irst_n = 1'b1;

        // Sequential fetch: the first edge only raises the request.
        step(enc(OP_ADD, 1, 2, 8'h04, 0), 1, 0, 0, 0, 1, 2, 16'h1234, mkB(16'h0000));
        step(enc(OP_ADD, 1, 2, 8'h04, 0), 1, 0, 0, 0, 0, 0, 16'h0,
             mk(16'h0003, OP_ADD, 16'h1234, 16'h0, 16'h0, 2, 4, 1, 1, 6'b000000));
        step(enc(OP_IMML, 6, 0, 8'hA5, 0), 1, 0, 0, 0, 1, 8, 16'h0030,
             mk(16'h0006, OP_IMML, 16'h0, 16'h0, 16'h00A5, 0, 5, 1, 6, 6'b000000));
        step(enc(OP_IMMH, 7, 2, 8'h5A, 0), 1, 0, 0, 0, 0, 0, 16'h0,
             mk(16'h0009, OP_IMMH, 16'h1234, 16'h0, 16'h5A00, 2, 4'hA, 1, 7, 6'b000000));
        step(enc(OP_STORE, 3, 2, 8'h81, 0), 1, 0, 0, 0, 0, 0, 16'h0,
             mk(16'h000C, OP_STORE, 16'h1234, 16'h0, 16'hFF81, 2, 1, 0, 0, 6'b010001));

        // Register-indirect jump to 0x30, then the branch at 0x30 not taken / taken.
        step(enc(OP_BRREG, 0, 8, 8'h00, 3'b001), 1, 3'b001, 0, 0, 0, 0, 16'h0,
             mk(16'h0030, OP_BRREG, 16'h0030, 16'h0, 16'h0, 8, 0, 0, 0, 6'b000000));
        step(enc(OP_BR, 0, 0, 8'hFE, 3'b100), 1, 3'b011, 0, 0, 0, 0, 16'h0,
             mk(16'h0033, OP_BR, 16'h0, 16'h0, 16'h0, 0, 4'hE, 0, 0, 6'b000000));
        step(enc(OP_BRREG, 0, 8, 8'h00, 3'b010), 1, 3'b010, 0, 0, 0, 0, 16'h0,
             mk(16'h0030, OP_BRREG, 16'h0030, 16'h0, 16'h0, 8, 0, 0, 0, 6'b000000));
        step(enc(OP_BR, 0, 0, 8'hFE, 3'b100), 1, 3'b100, 0, 0, 0, 0, 16'h0,
             mk(16'h002D, OP_BR, 16'h0, 16'h0, 16'h0, 0, 4'hE, 0, 0, 6'b000000));

        // LOAD r3 then ADD reading r3: one bubble, then the ADD.
        step(enc(OP_LOAD, 3, 2, 8'h10, 0), 1, 0, 0, 0, 0, 0, 16'h0,
             mk(16'h0030, OP_LOAD, 16'h1234, 16'h0, 16'h0010, 2, 0, 1, 3, 6'b101001));
        step(enc(OP_ADD, 1, 3, 8'h02, 0), 1, 0, 0, 0, 1, 3, 16'h0333, mkB(16'h0030));
        step(enc(OP_ADD, 1, 3, 8'h02, 0), 1, 0, 0, 0, 0, 0, 16'h0,
             mk(16'h0033, OP_ADD, 16'h0333, 16'h1234, 16'h0, 3, 2, 1, 1, 6'b000000));

        // Three cycles with no valid instruction.
        for (int k = 0; k < 3; k++) begin
            step(24'h0, 0, 0, 0, 0, 0, 0, 16'h0, mkB(16'h0033));
        end
        e16 = mk(16'h0036, OP_IMML, 16'h0, 16'h0, 16'h0011, 0, 1, 1, 9, 6'b000000);
        step(enc(OP_IMML, 9, 0, 8'h11, 0), 1, 0, 0, 0, 0, 0, 16'h0, e16);

        // Stall two cycles, flush in the second: frozen, then bubble, then resume.
        step(enc(OP_IMMH, 10, 0, 8'h22, 0), 1, 0, 1, 0, 0, 0, 16'h0, e16);
        step(enc(OP_IMMH, 10, 0, 8'h22, 0), 1, 0, 1, 1, 0, 0, 16'h0, mkB(16'h0036));
        step(enc(OP_IMMH, 10, 0, 8'h22, 0), 1, 0, 0, 0, 0, 0, 16'h0,
             mk(16'h0039, OP_IMMH, 16'h0, 16'h1234, 16'h2200, 0, 2, 1, 10, 6'b000000));

        // Write r5 while reading it, then read it again.
        step(enc(OP_ADD, 11, 5, 8'h05, 0), 1, 0, 0, 0, 1, 5, 16'hBEEF,
             mk(16'h003C, OP_ADD, R5_SAME_CYCLE, R5_SAME_CYCLE, 16'h0, 5, 5, 1, 11, 6'b000000));
        step(enc(OP_ADD, 12, 5, 8'h05, 0), 1, 0, 0, 0, 0, 0, 16'h0,
             mk(16'h003F, OP_ADD, 16'hBEEF, 16'hBEEF, 16'h0, 5, 5, 1, 12, 6'b000000));

        // DBLOAD r4 then DBSTORE using r4 as sr2: hazard through sr2.
        step(enc(OP_DBLOAD, 4, 0, 8'hF0, 0), 1, 0, 0, 0, 0, 0, 16'h0,
             mk(16'h0042, OP_DBLOAD, 16'h0, 16'h0, 16'hFFF0, 0, 0, 1, 4, 6'b000101));
        step(enc(OP_DBSTORE, 0, 1, 8'h04, 0), 1, 0, 0, 0, 0, 0, 16'h0, mkB(16'h0042));
        step(enc(OP_DBSTORE, 0, 1, 8'h04, 0), 1, 0, 0, 0, 0, 0, 16'h0,
             mk(16'h0045, OP_DBSTORE, 16'h0, 16'h0, 16'h0004, 1, 4, 0, 0, 6'b000011));
        step(24'h0, 0, 0, 0, 0, 0, 0, 16'h0, mkB(16'h0045));

        @(negedge iclk);
        #1;
        nTests++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_pipe.md
Name: fetch_decode_pipe

Overview:
Parametrised fetch/decode front end for the NN soft CPU. It owns the PC, issues instruction-memory requests, decodes the fixed 24-bit instruction, reads the register file and registers everything into the FD/EX pipeline register.
- New over the previous generation: memory-valid handshake, downstream stall, load-use bubble insertion, sign-extended branch offsets, register-indirect branches and distinct opcode encodings.

Parameters:
DATA_W, 16, register/data width
ADDR_W, 16, instruction address (PC) width
PC_STEP, 3, address increment per instruction
NUM_REGS, 16, register count; fixed by the 4-bit register fields

Ports:
iclk  in  1  clock
irst_n  in  1  async active-low reset
oInstrAddr  out  ADDR_W  fetch address (the PC)
oInstrReq  out  1  fetch request
iInstr  in  24  fetched instruction
iInstrValid  in  1  iInstr valid this cycle
iStall  in  1  EX cannot accept; hold FD/EX register
iFlush  in  1  squash the instruction being decoded
iNVZ  in  3  flags from EX
iWriteReg  in  1  writeback enable
iWriteRegAddr  in  4  writeback register
iWriteRegData  in  DATA_W  writeback data
oValid  out  1  FD/EX register holds a real instruction
oOpcode  out  5  decoded opcode
oData1, oData2  out  DATA_W  sr1/sr2 contents
oImm  out  DATA_W  formatted immediate
oSr1, oSr2  out  4  source register numbers
oWriteReg  out  1  instruction writes rd
oWriteRegAddr  out  4  rd
oMemRead, oMemWrite, oMemtoReg, oBustoReg, oBusWrite, oALUSrc  out  1 each  control bits

Behaviour:
- Instruction fields: opcode[4:0], rd[8:5], sr1[12:9], sr2[16:13], imm8[20:13], cond[23:21].
- Reset (irst_n low, async): PC=0, every output 0, state FETCH, register file all 0. oInstrReq goes to 1 on the first clock after reset release.
- FSM:
  - FETCH: oInstrReq=1.
    - iInstrValid=1 → decode.
    - iInstrValid=0 → WAIT, PC held.
  - WAIT: oInstrReq=1, PC held; return to FETCH on iInstrValid.
  - HOLD: entered on iStall; FD/EX register and PC frozen; exit when iStall=0.
- Decode on valid instruction, no stall:
  - FD/EX register loads; oValid=1.
  - PC update:
    - PC+PC_STEP by default.
    - BRANCH with cond true: PC + PC_STEP*(sext(imm8)+1).
    - BRANCH_REG with cond true: PC=register[sr1].
    - All PC arithmetic wraps modulo 2^ADDR_W.
- Load-use hazard: FD/EX holds a valid LOAD or DBLOAD, and its rd equals the current sr1 or sr2.
  - Insert a bubble: oValid=0, all control outputs 0, PC and instruction held for one cycle.
  - A stalled instruction is decoded again in the next cycle.
- iFlush=1: the next FD/EX load is a bubble, and the PC is not advanced by the flushed instruction.
  - iFlush has priority over the hazard check, which has priority over iStall.
  - iStall with iFlush: the register is cleared to a bubble.
- Control decode:
  - oWriteReg=1 except STORE, DBSTORE and BRANCH*; oWriteRegAddr=0 when oWriteReg=0.
  - oMemRead and oMemtoReg: LOAD only.
  - oMemWrite: STORE only.
  - oBustoReg: DBLOAD only.
  - oBusWrite: DBSTORE only.
  - oALUSrc=1 for LOAD, STORE, DBLOAD, DBSTORE.
- Immediate:
  - IMML: zero-extended imm8.
  - IMMH: imm8<<8.
  - Memory ops: sext(imm8).
  - Otherwise 0.
- Register file: written on posedge when iWriteReg=1. Reads in the same cycle return the old value (no bypass) unless RF_BYPASS_EN is defined.

Optional Feature:
RF_BYPASS_EN
- Defined: when iWriteReg=1 and iWriteRegAddr equals sr1/sr2, oData1/oData2 capture iWriteRegData.
- Undefined: they capture the stale register value, and software must insert a gap.

Decomposition:
- Package fd_pkg:
  - Opcode localparams: IMML=5'b00110, IMMH=5'b00111, BRANCH=5'b01000, BRANCH_REG=5'b01001, LOAD=5'b01010, STORE=5'b01011, DBLOAD=5'b01100, DBSTORE=5'b01101.
  - FSM state enum {FETCH, WAIT, HOLD}.
  - Field-slice constants.
- One sub-module: the existing CCodeEval (cond, NVZ → cond_true), instantiated unchanged.

Test Plan:
- Reset, then 4 sequential valid non-branch fetches → oInstrAddr 0,3,6,9,12; oValid=1 from cycle 2.
- BRANCH at PC=0x30, cond true, imm8=0xFE → next PC = 0x30 + 3*(-1) = 0x2D; same instruction with cond false → 0x33.
- LOAD r3 followed by ADD r1=r3+r2 → exactly one bubble (oValid=0, oMemRead=0); ADD issues next cycle with oSr1=3.
- iInstrValid low for 3 cycles → oInstrAddr constant, oValid=0 during the gap, oInstrReq stays 1.
- iStall held 2 cycles with iFlush pulsed in the second → outputs frozen in cycle 1, bubble after the flush.
- Write r5=0xBEEF while decoding a read of r5 → 0xBEEF with RF_BYPASS_EN, old value without it.
